ram_program_loader: RTL and testbench

//  Upstream feeder for the 16-word program RAM. Before the CPU runs, it accepts a

---
 rtl/ram_program_loader_pkg.sv | 13 +
 rtl/ram_program_loader.sv | 127 ++++++++++++
 tb/tb_ram_program_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_program_loader_pkg.sv
// Shared constants and FSM state type for the program RAM loader.
package ram_program_loader_pkg;

  localparam int unsigned LDR_DATA_WIDTH = 8;
  localparam int unsigned LDR_MEM_SIZE   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } loader_state_t;

endpackage

// File: rtl/ram_program_loader.sv
// Streams a byte sequence into sequential program RAM addresses from 0 and
// holds the CPU off while loading; pulses done and keeps a running checksum.
module ram_program_loader
  import ram_program_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LDR_DATA_WIDTH,
  parameter int unsigned MEM_SIZE   = LDR_MEM_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_len,
  input  logic                  i_abort,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_we,
  output logic [DATA_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_checksum
);

  localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE);
  // One extra bit so a full-depth length (MEM_SIZE) is representable.
  localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  logic                  hs;
  logic                  last_word;
  logic [LEN_WIDTH-1:0]  len_clamped;

  always_comb begin
    if ((i_len == '0) || (i_len > DATA_WIDTH'(MEM_SIZE))) begin
      len_clamped = LEN_WIDTH'(MEM_SIZE);
    end else begin
      len_clamped = LEN_WIDTH'(i_len);
    end
  end

  // Abort wins over a concurrent handshake: that byte is dropped.
  assign hs        = (state_q == LOAD) && i_valid && !i_abort;
  assign last_word = ({1'b0, cnt_q} == (len_q - LEN_WIDTH'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    sum_d   = sum_q;

    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          cnt_d   = '0;
          sum_d   = '0;
          len_d   = len_clamped;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (hs) begin
          we_d   = 1'b1;
          addr_d = DATA_WIDTH'(cnt_q);
          data_d = i_data;
          sum_d  = sum_q + i_data;
          cnt_d  = cnt_q + ADDR_WIDTH'(1);
          if (last_word) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = !i_abort;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
    end
  end

  assign o_ready    = (state_q == LOAD);
  assign o_busy     = (state_q != IDLE);
  assign o_we       = we_q;
  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_done     = done_q;
  assign o_checksum = sum_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader: per-cycle comparison against a
// behavioural load model plus literal checks on each scenario's outcome.
module tb_ram_program_loader;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_len;
  logic       i_abort;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_we;
  logic [7:0] o_addr;
  logic [7:0] o_data;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_checksum;

  int checks;
  int failures;
  int wr_cnt;
  int done_cnt;

  ram_program_loader dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_abort    (i_abort),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_we       (o_we),
    .o_addr     (o_addr),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_checksum (o_checksum)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load is "active" while bytes remain, then one trailing cycle
  // while the final write sits on the bus; done follows that trailing cycle.
  bit         m_loading;
  bit         m_trailing;
  int         m_taken;
  int         m_len;
  logic [7:0] m_sum;
  bit         e_we;
  logic [7:0] e_addr;
  logic [7:0] e_data;
  bit         e_done;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_loading  <= 1'b0;
      m_trailing <= 1'b0;
      m_taken    <= 0;
      m_len      <= 0;
      m_sum      <= 8'h00;
      e_we       <= 1'b0;
      e_done     <= 1'b0;
    end else begin
      e_we   <= 1'b0;
      e_done <= 1'b0;
      if (m_trailing) begin
        m_trailing <= 1'b0;
        e_done     <= !i_abort;
      end else if (m_loading) begin
        if (i_abort) begin
          m_loading <= 1'b0;
        end else if (i_valid) begin
          e_we    <= 1'b1;
          e_addr  <= 8'(m_taken);
          e_data  <= i_data;
          m_sum   <= m_sum + i_data;
          m_taken <= m_taken + 1;
          if (m_taken + 1 == m_len) begin
            m_loading  <= 1'b0;
            m_trailing <= 1'b1;
          end
        end
      end else if (i_start && !i_abort) begin
        m_loading <= 1'b1;
        m_taken   <= 0;
        m_sum     <= 8'h00;
        m_len     <= (i_len == 8'd0 || i_len > 8'd16) ? 16 : int'(i_len);
      end
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("cyc_we", 32'(o_we), 32'(e_we));
      if (e_we) begin
        chk("cyc_addr", 32'(o_addr), 32'(e_addr));
        chk("cyc_data", 32'(o_data), 32'(e_data));
      end
      chk("cyc_done", 32'(o_done), 32'(e_done));
      chk("cyc_busy", 32'(o_busy), 32'(m_loading | m_trailing));
      chk("cyc_ready", 32'(o_ready), 32'(m_loading));
      chk("cyc_checksum", 32'(o_checksum), 32'(m_sum));
      if (o_we) wr_cnt++;
      if (o_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] len);
    i_start = 1'b1;
    i_len   = len;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    bit ok;
    ok      = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (o_ready) ok = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  int wr0;
  int dn0;

  initial begin
    checks   = 0;
    failures = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_len    = 8'd0;
    i_abort  = 1'b0;
    i_valid  = 1'b0;
    i_data   = 8'd0;

    #3;
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_checksum", 32'(o_checksum), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    #9 i_rst = 1'b0;
    tick();

    // Full load, i_len=0 means 16 words.
    wr0 = wr_cnt; dn0 = done_cnt;
    start_load(8'd0);
    for (int k = 0; k < 16; k++) send(8'(8'h10 + k));
    chk("full_last_we", 32'(o_we), 32'd1);
    chk("full_last_addr", 32'(o_addr), 32'd15);
    chk("full_busy_finish", 32'(o_busy), 32'd1);
    chk("full_no_early_done", 32'(o_done), 32'd0);
    tick();
    chk("full_done_k2", 32'(o_done), 32'd1);
    chk("full_busy_k2", 32'(o_busy), 32'd0);
    chk("full_checksum", 32'(o_checksum), 32'h78);
    tick();
    chk("full_done_pulse", 32'(o_done), 32'd0);
    chk("full_checksum_hold", 32'(o_checksum), 32'h78);
    chk("full_writes", 32'(wr_cnt - wr0), 32'd16);
    chk("full_dones", 32'(done_cnt - dn0), 32'd1);

    // Throttled source with idle gaps.
    wr0 = wr_cnt; dn0 = done_cnt;
    start_load(8'd3);
    send(8'hA0); tick(); tick();
    send(8'hB1); tick(); tick();
    send(8'hC2);
    tick(); tick();
    chk("thr_writes", 32'(wr_cnt - wr0), 32'd3);
    chk("thr_dones", 32'(done_cnt - dn0), 32'd1);
    chk("thr_checksum", 32'(o_checksum), 32'h13);

    // Clamp: i_len=20 accepts only 16 bytes.
    wr0 = wr_cnt; dn0 = done_cnt;
    start_load(8'd20);
    for (int k = 0; k < 16; k++) send(8'(k + 1));
    chk("clamp_ready_low", 32'(o_ready), 32'd0);
    i_valid = 1'b1;
    i_data  = 8'hEE;
    tick(); tick(); tick();
    i_valid = 1'b0;
    chk("clamp_writes", 32'(wr_cnt - wr0), 32'd16);
    chk("clamp_dones", 32'(done_cnt - dn0), 32'd1);
    chk("clamp_checksum", 32'(o_checksum), 32'h88);

    // Abort with a valid third byte in the abort cycle.
    wr0 = wr_cnt; dn0 = done_cnt;
    start_load(8'd5);
    send(8'h01);
    send(8'h02);
    i_valid = 1'b1;
    i_data  = 8'h55;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    i_valid = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_no_we", 32'(o_we), 32'd0);
    tick(); tick(); tick();
    chk("abort_writes", 32'(wr_cnt - wr0), 32'd2);
    chk("abort_dones", 32'(done_cnt - dn0), 32'd0);
    chk("abort_checksum", 32'(o_checksum), 32'h03);

    // Restart guard: i_start mid-load is ignored.
    wr0 = wr_cnt; dn0 = done_cnt;
    start_load(8'd4);
    send(8'h11);
    start_load(8'd2);
    send(8'h22);
    send(8'h33);
    chk("restart_still_busy", 32'(o_busy), 32'd1);
    send(8'h44);
    tick(); tick();
    chk("restart_writes", 32'(wr_cnt - wr0), 32'd4);
    chk("restart_dones", 32'(done_cnt - dn0), 32'd1);
    chk("restart_checksum", 32'(o_checksum), 32'hAA);

    // Asynchronous reset mid-load.
    start_load(8'd8);
    send(8'h05);
    chk("areset_pre_we", 32'(o_we), 32'd1);
    i_valid = 1'b1;
    i_data  = 8'h66;
    #3 i_rst = 1'b1;
    #1;
    chk("areset_we", 32'(o_we), 32'd0);
    chk("areset_busy", 32'(o_busy), 32'd0);
    chk("areset_ready", 32'(o_ready), 32'd0);
    chk("areset_checksum", 32'(o_checksum), 32'd0);
    chk("areset_addr", 32'(o_addr), 32'd0);
    chk("areset_data", 32'(o_data), 32'd0);
    tick(); tick();
    i_rst = 1'b0;
    wr0 = wr_cnt; dn0 = done_cnt;
    tick(); tick(); tick(); tick();
    i_valid = 1'b0;
    chk("areset_writes_after", 32'(wr_cnt - wr0), 32'd0);
    chk("areset_dones_after", 32'(done_cnt - dn0), 32'd0);
    chk("areset_idle", 32'(o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
